// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and constants for the CAN receive CRC sequencer
package can_pkg;

    localparam int CRC_WIDTH           = 15;
    localparam int ID_STD_BITS         = 11;
    localparam int ID_EXT_BITS         = 18;
    localparam int DLC_BITS            = 4;
    localparam int STUFF_LIMIT_DEFAULT = 5;

    typedef enum logic [3:0] {
        ST_INTEGRATE,
        ST_IDLE,
        ST_ID_A,
        ST_SRR_RTR,
        ST_IDE_BIT,
        ST_ID_B,
        ST_RTR_X,
        ST_R1,
        ST_R0,
        ST_DLC_F,
        ST_DATA,
        ST_CRC_F,
        ST_CRC_DEL,
        ST_WAIT_IDLE
    } can_state_e;

    // Remote frames carry no data regardless of DLC; larger DLC codes clamp to max_bytes.
    function automatic logic [7:0] data_bit_count(input logic [3:0] dlc,
                                                  input logic       rtr,
                                                  input logic [3:0] max_bytes);
        logic [3:0] n;
        n = (dlc > max_bytes) ? max_bytes : dlc;
        return rtr ? 8'd0 : {1'b0, n, 3'b000};
    endfunction

endpackage

// File: rtl/can_destuff.sv
// rtl/can_destuff.sv - run-length tracker flagging stuff bits and stuff errors
module can_destuff
    import can_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strb_i,
    input  logic bit_i,
    input  logic sof_i,
    input  logic active_i,
    output logic stuff_bit_o,
    output logic stuff_err_o
);

    localparam int RUN_W = $clog2(STUFF_LIMIT + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;

    assign stuff_bit_o = active_i && (run_q == RUN_W'(STUFF_LIMIT));
    assign stuff_err_o = stuff_bit_o && (bit_i == last_q);

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (strb_i) begin
            if (sof_i) begin
                run_d  = RUN_W'(1);
                last_d = bit_i;
            end else if (active_i) begin
                if (stuff_bit_o || (bit_i != last_q)) begin
                    run_d  = RUN_W'(1);
                    last_d = bit_i;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_crc_sequencer.sv
// rtl/can_crc_sequencer.sv - CAN receive field tracker that drives the CRC-15 LFSR
// and checks the received CRC sequence against it.
module can_crc_sequencer
    import can_pkg::*;
#(
    parameter int IDLE_BITS      = 11,
    parameter int MAX_DATA_BYTES = 8,
    parameter int STUFF_LIMIT    = 5
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 SAMPLE_STRB,
    input  logic                 SAMPLE_BIT,
    input  logic [CRC_WIDTH-1:0] CRC_IN,
    output logic                 CRC_CLEAR,
    output logic                 CRC_STRB,
    output logic                 CRC_BITVAL,
    output logic                 BUSY,
    output logic                 FRAME_OK,
    output logic                 CRC_ERR,
    output logic                 STUFF_ERR,
    output logic                 FORM_ERR,
    output logic [28:0]          ID,
    output logic                 IDE,
    output logic                 RTR,
    output logic [3:0]           DLC
);

    localparam logic [3:0] MAX_BYTES = 4'(MAX_DATA_BYTES);

    can_state_e           state_q;
    logic [7:0]           cnt_q;
    logic [28:0]          id_sh_q;
    logic                 ide_sh_q, rtr_sh_q;
    logic [3:0]           dlc_sh_q;
    logic [CRC_WIDTH-1:0] rx_crc_q;
    logic                 feed_pend_q, feed_bit_q, strb_pend_q;
    logic                 bitval_q, strb_q, clear_q, busy_q;
    logic                 ok_pend_q, crcerr_pend_q, stuff_pend_q, form_pend_q;
    logic                 frame_ok_q, crc_err_q, stuff_err_q, form_err_q;
    logic [28:0]          id_q;
    logic                 ide_q, rtr_q;
    logic [3:0]           dlc_q;

    logic                 stuffed_w, sof_w, stuff_bit_w, stuff_err_w, skip_w, feed_w;
    logic [3:0]           dlc_next_w;
    logic [7:0]           dlc_bits_w, data_bits_w;

    assign stuffed_w  = state_q inside {ST_ID_A, ST_SRR_RTR, ST_IDE_BIT, ST_ID_B, ST_RTR_X,
                                        ST_R1, ST_R0, ST_DLC_F, ST_DATA, ST_CRC_F};
    assign sof_w      = (state_q == ST_IDLE) && !SAMPLE_BIT;
    assign skip_w     = stuffed_w && stuff_bit_w;
    assign feed_w     = SAMPLE_STRB && !skip_w &&
                        (sof_w || (stuffed_w && (state_q != ST_CRC_F)));
    assign dlc_next_w = {dlc_sh_q[2:0], SAMPLE_BIT};
    assign dlc_bits_w  = data_bit_count(dlc_next_w, rtr_sh_q, MAX_BYTES);
    assign data_bits_w = data_bit_count(dlc_sh_q, rtr_sh_q, MAX_BYTES);

    can_destuff #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_destuff (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .strb_i     (SAMPLE_STRB),
        .bit_i      (SAMPLE_BIT),
        .sof_i      (sof_w),
        .active_i   (stuffed_w),
        .stuff_bit_o(stuff_bit_w),
        .stuff_err_o(stuff_err_w)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_INTEGRATE;
            cnt_q         <= '0;
            id_sh_q       <= '0;
            ide_sh_q      <= 1'b0;
            rtr_sh_q      <= 1'b0;
            dlc_sh_q      <= '0;
            rx_crc_q      <= '0;
            feed_pend_q   <= 1'b0;
            feed_bit_q    <= 1'b0;
            strb_pend_q   <= 1'b0;
            bitval_q      <= 1'b0;
            strb_q        <= 1'b0;
            clear_q       <= 1'b1;
            busy_q        <= 1'b0;
            ok_pend_q     <= 1'b0;
            crcerr_pend_q <= 1'b0;
            stuff_pend_q  <= 1'b0;
            form_pend_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            stuff_err_q   <= 1'b0;
            form_err_q    <= 1'b0;
            id_q          <= '0;
            ide_q         <= 1'b0;
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
        end else begin
            // Verdicts decided on a sample edge surface one cycle later.
            frame_ok_q    <= ok_pend_q;
            crc_err_q     <= crcerr_pend_q;
            stuff_err_q   <= stuff_pend_q;
            form_err_q    <= form_pend_q;
            ok_pend_q     <= 1'b0;
            crcerr_pend_q <= 1'b0;
            stuff_pend_q  <= 1'b0;
            form_pend_q   <= 1'b0;
            if (ok_pend_q || crcerr_pend_q || stuff_pend_q || form_pend_q) begin
                busy_q <= 1'b0;
            end
            if (ok_pend_q) begin
                id_q  <= id_sh_q;
                ide_q <= ide_sh_q;
                rtr_q <= rtr_sh_q;
                dlc_q <= dlc_sh_q;
            end

            // LFSR feed: bit value one cycle after the sample, strobe one cycle after that.
            strb_q      <= strb_pend_q;
            strb_pend_q <= 1'b0;
            feed_pend_q <= 1'b0;
            if (feed_pend_q) begin
                bitval_q    <= feed_bit_q;
                strb_pend_q <= 1'b1;
            end
            if (feed_w) begin
                feed_pend_q <= 1'b1;
                feed_bit_q  <= SAMPLE_BIT;
            end

            if (SAMPLE_STRB) begin
                if (skip_w) begin
                    if (stuff_err_w) begin
                        stuff_pend_q <= 1'b1;
                        state_q      <= ST_WAIT_IDLE;
                        cnt_q        <= '0;
                    end
                end else begin
                    unique case (state_q)
                        ST_INTEGRATE, ST_WAIT_IDLE: begin
                            if (!SAMPLE_BIT) begin
                                cnt_q <= '0;
                            end else if (cnt_q == 8'(IDLE_BITS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_IDLE;
                                clear_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_IDLE: begin
                            if (!SAMPLE_BIT) begin
                                state_q  <= ST_ID_A;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                clear_q  <= 1'b0;
                                id_sh_q  <= '0;
                                ide_sh_q <= 1'b0;
                                rtr_sh_q <= 1'b0;
                            end
                        end
                        ST_ID_A: begin
                            id_sh_q <= {id_sh_q[27:0], SAMPLE_BIT};
                            if (cnt_q == 8'(ID_STD_BITS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_SRR_RTR;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_SRR_RTR: begin
                            rtr_sh_q <= SAMPLE_BIT;
                            state_q  <= ST_IDE_BIT;
                        end
                        ST_IDE_BIT: begin
                            ide_sh_q <= SAMPLE_BIT;
                            state_q  <= SAMPLE_BIT ? ST_ID_B : ST_R0;
                        end
                        ST_ID_B: begin
                            id_sh_q <= {id_sh_q[27:0], SAMPLE_BIT};
                            if (cnt_q == 8'(ID_EXT_BITS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_RTR_X;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_RTR_X: begin
                            rtr_sh_q <= SAMPLE_BIT;
                            state_q  <= ST_R1;
                        end
                        ST_R1: state_q <= ST_R0;
                        ST_R0: begin
                            cnt_q   <= '0;
                            state_q <= ST_DLC_F;
                        end
                        ST_DLC_F: begin
                            dlc_sh_q <= dlc_next_w;
                            if (cnt_q == 8'(DLC_BITS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= (dlc_bits_w == 8'd0) ? ST_CRC_F : ST_DATA;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_DATA: begin
                            if (cnt_q == data_bits_w - 8'd1) begin
                                cnt_q   <= '0;
                                state_q <= ST_CRC_F;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_CRC_F: begin
                            rx_crc_q <= {rx_crc_q[CRC_WIDTH-2:0], SAMPLE_BIT};
                            if (cnt_q == 8'(CRC_WIDTH - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_CRC_DEL;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_CRC_DEL: begin
                            if (!SAMPLE_BIT) begin
                                form_pend_q <= 1'b1;
                            end else if (rx_crc_q == CRC_IN) begin
                                ok_pend_q <= 1'b1;
                            end else begin
                                crcerr_pend_q <= 1'b1;
                            end
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_IDLE;
                        end
                        default: begin
                            cnt_q   <= '0;
                            state_q <= ST_INTEGRATE;
                        end
                    endcase
                end
            end
        end
    end

    assign CRC_CLEAR  = clear_q;
    assign CRC_STRB   = strb_q;
    assign CRC_BITVAL = bitval_q;
    assign BUSY       = busy_q;
    assign FRAME_OK   = frame_ok_q;
    assign CRC_ERR    = crc_err_q;
    assign STUFF_ERR  = stuff_err_q;
    assign FORM_ERR   = form_err_q;
    assign ID         = id_q;
    assign IDE        = ide_q;
    assign RTR        = rtr_q;
    assign DLC        = dlc_q;

endmodule

// File: tb/tb_can_crc_sequencer.sv
// tb/tb_can_crc_sequencer.sv - randomized bench with a frame-level CAN receive model
module tb_can_crc_sequencer;

    logic        CLK, RESET_N, SAMPLE_STRB, SAMPLE_BIT;
    logic [14:0] CRC_IN;
    logic        CRC_CLEAR, CRC_STRB, CRC_BITVAL, BUSY;
    logic        FRAME_OK, CRC_ERR, STUFF_ERR, FORM_ERR;
    logic [28:0] ID;
    logic        IDE, RTR;
    logic [3:0]  DLC;

    int n_chk  = 0;
    int n_pass = 0;

    can_crc_sequencer dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .SAMPLE_STRB(SAMPLE_STRB),
        .SAMPLE_BIT (SAMPLE_BIT),
        .CRC_IN     (CRC_IN),
        .CRC_CLEAR  (CRC_CLEAR),
        .CRC_STRB   (CRC_STRB),
        .CRC_BITVAL (CRC_BITVAL),
        .BUSY       (BUSY),
        .FRAME_OK   (FRAME_OK),
        .CRC_ERR    (CRC_ERR),
        .STUFF_ERR  (STUFF_ERR),
        .FORM_ERR   (FORM_ERR),
        .ID         (ID),
        .IDE        (IDE),
        .RTR        (RTR),
        .DLC        (DLC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the external CRC-15 LFSR unit.
    logic [14:0] lfsr_q;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       lfsr_q <= '0;
        else if (CRC_CLEAR) lfsr_q <= '0;
        else if (CRC_STRB)  lfsr_q <= {lfsr_q[13:0], 1'b0} ^ ((CRC_BITVAL ^ lfsr_q[14]) ? 15'h4599 : 15'h0);
    end
    assign CRC_IN = lfsr_q;

    int n_ok, n_crc, n_stf, n_frm, viol;
    bit prev_clear;
    bit fed[$];
    bit tx[$];
    bit exp_fed[$];
    logic snap_ok, snap_crc, snap_stf, snap_frm, snap_busy;

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (CRC_STRB) begin
                fed.push_back(CRC_BITVAL);
                if (CRC_CLEAR || prev_clear) viol++;
            end
            if (FRAME_OK)  n_ok++;
            if (CRC_ERR)   n_crc++;
            if (STUFF_ERR) n_stf++;
            if (FORM_ERR)  n_frm++;
        end
        prev_clear = CRC_CLEAR;
    end

    logic [28:0] m_id;
    logic        m_ide, m_rtr;
    logic [3:0]  m_dlc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic clear_counts();
        n_ok = 0; n_crc = 0; n_stf = 0; n_frm = 0;
        fed.delete();
    endtask

    task automatic send_bit(input bit b);
        @(negedge CLK);
        SAMPLE_STRB = 1'b1;
        SAMPLE_BIT  = b;
        @(posedge CLK);
        @(negedge CLK);
        SAMPLE_STRB = 1'b0;
        @(posedge CLK);
        #1;
        snap_ok   = FRAME_OK;
        snap_crc  = CRC_ERR;
        snap_stf  = STUFF_ERR;
        snap_frm  = FORM_ERR;
        snap_busy = BUSY;
        @(posedge CLK);
        @(posedge CLK);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Builds the on-wire bit sequence: fields, CRC by polynomial division, bit stuffing.
    task automatic build_frame(input bit ide, input logic [28:0] id, input bit rtr,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input int flip, input bit del);
        bit          raw[$];
        bit          all[$];
        logic [10:0] a;
        logic [15:0] r;
        logic [14:0] crc;
        int          nb;
        int          run;
        bit          last;
        raw.delete();
        tx.delete();
        raw.push_back(1'b0);
        a = ide ? id[28:18] : id[10:0];
        for (int i = 10; i >= 0; i--) raw.push_back(a[i]);
        if (ide) begin
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end else begin
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63-i]);
        exp_fed = raw;
        r = '0;
        for (int i = 0; i < raw.size() + 15; i++) begin
            r = {r[14:0], (i < raw.size()) ? raw[i] : 1'b0};
            if (r[15]) r = r ^ 16'hC599;
        end
        crc = r[14:0];
        if (flip >= 0) crc[flip] = ~crc[flip];
        all = raw;
        for (int i = 14; i >= 0; i--) all.push_back(crc[i]);
        run  = 0;
        last = 1'b0;
        for (int i = 0; i < all.size(); i++) begin
            if (i > 0 && run == 5) begin
                tx.push_back(!last);
                last = !last;
                run  = 1;
            end
            if (i > 0 && all[i] == last) run++;
            else begin
                run  = 1;
                last = all[i];
            end
            tx.push_back(all[i]);
        end
        tx.push_back(del);
    endtask

    task automatic run_frame(input string tag, input bit ide, input logic [28:0] id, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input int flip, input bit del, input bit accept);
        bit busy_mid;
        bit e_ok, e_crc, e_frm;
        int mism;
        busy_mid = 1'b0;
        build_frame(ide, id, rtr, dlc, data, flip, del);
        clear_counts();
        for (int i = 0; i < tx.size(); i++) begin
            send_bit(tx[i]);
            if (i == tx.size() - 2) busy_mid = snap_busy;
        end
        e_frm = accept && !del;
        e_crc = accept && del && (flip >= 0);
        e_ok  = accept && del && (flip < 0);
        check_eq({tag, ".busy_mid"}, 32'(busy_mid), 32'(accept));
        check_eq({tag, ".frame_ok"}, 32'(snap_ok), 32'(e_ok));
        check_eq({tag, ".crc_err"}, 32'(snap_crc), 32'(e_crc));
        check_eq({tag, ".form_err"}, 32'(snap_frm), 32'(e_frm));
        check_eq({tag, ".busy_end"}, 32'(snap_busy), 32'd0);
        check_eq({tag, ".pulses"}, 32'(n_ok + n_crc + n_frm + n_stf), 32'(accept));
        check_eq({tag, ".strb_cnt"}, 32'(fed.size()), accept ? 32'(exp_fed.size()) : 32'd0);
        if (accept) begin
            mism = 0;
            for (int i = 0; i < fed.size() && i < exp_fed.size(); i++)
                if (fed[i] != exp_fed[i]) mism++;
            check_eq({tag, ".fed_bits"}, 32'(mism), 32'd0);
        end
        if (e_ok) begin
            m_id  = ide ? id : {18'd0, id[10:0]};
            m_ide = ide;
            m_rtr = rtr;
            m_dlc = dlc;
        end
        check_eq({tag, ".id"}, 32'(ID), 32'(m_id));
        check_eq({tag, ".ide"}, 32'(IDE), 32'(m_ide));
        check_eq({tag, ".rtr"}, 32'(RTR), 32'(m_rtr));
        check_eq({tag, ".dlc"}, 32'(DLC), 32'(m_dlc));
    endtask

    initial begin
        bit          r_ide, r_rtr, r_del;
        logic [28:0] r_id;
        logic [3:0]  r_dlc;
        int          r_flip;

        RESET_N     = 1'b0;
        SAMPLE_STRB = 1'b0;
        SAMPLE_BIT  = 1'b1;
        m_id = '0; m_ide = 1'b0; m_rtr = 1'b0; m_dlc = '0;
        viol = 0;
        repeat (3) @(negedge CLK);
        check_eq("rst.crc_clear", 32'(CRC_CLEAR), 32'd1);
        check_eq("rst.busy", 32'(BUSY), 32'd0);
        check_eq("rst.crc_strb", 32'(CRC_STRB), 32'd0);
        check_eq("rst.pulses", 32'({FRAME_OK, CRC_ERR, STUFF_ERR, FORM_ERR}), 32'd0);
        check_eq("rst.id", 32'(ID), 32'd0);
        check_eq("rst.dlc", 32'(DLC), 32'd0);
        RESET_N = 1'b1;

        idle_bits(11);
        run_frame("std123", 1'b0, 29'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1, 1'b1, 1'b1);
        idle_bits(11);
        run_frame("crcflip", 1'b0, 29'h7F0, 1'b0, 4'd2, 64'h5A3C_0000_0000_0000, 3, 1'b1, 1'b1);

        idle_bits(11);
        clear_counts();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        send_bit(1'b0);
        check_eq("stf.pulse", 32'(snap_stf), 32'd1);
        check_eq("stf.busy", 32'(snap_busy), 32'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("stf.strb_cnt", 32'(fed.size()), 32'd5);
        check_eq("stf.once", 32'(n_stf), 32'd1);
        check_eq("stf.others", 32'(n_ok + n_crc + n_frm), 32'd0);
        idle_bits(5);
        run_frame("stf.ignored", 1'b0, 29'h055, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1, 1'b1, 1'b0);
        idle_bits(11);
        run_frame("stf.after", 1'b0, 29'h055, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1, 1'b1, 1'b1);

        idle_bits(11);
        run_frame("id0", 1'b0, 29'h000, 1'b0, 4'd0, 64'h0, -1, 1'b1, 1'b1);
        check_eq("id0.strb19", 32'(fed.size()), 32'd19);

        idle_bits(11);
        run_frame("extrtr", 1'b1, 29'h1ABCDEF0, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b1, 1'b1);
        check_eq("extrtr.strb39", 32'(fed.size()), 32'd39);

        idle_bits(11);
        run_frame("formdel", 1'b0, 29'h2F1, 1'b0, 4'd3, 64'h1122_3300_0000_0000, -1, 1'b0, 1'b1);

        idle_bits(11);
        run_frame("dlc15", 1'b0, 29'h6A5, 1'b0, 4'd15, {$urandom, $urandom}, -1, 1'b1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            r_ide  = 1'($urandom_range(0, 1));
            r_rtr  = ($urandom_range(0, 3) == 0);
            r_id   = 29'($urandom);
            r_dlc  = 4'($urandom_range(0, 15));
            r_flip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : -1;
            r_del  = ($urandom_range(0, 7) != 0);
            idle_bits(11);
            run_frame($sformatf("rnd%0d", n), r_ide, r_id, r_rtr, r_dlc, {$urandom, $urandom},
                      r_flip, r_del, 1'b1);
        end

        idle_bits(11);
        build_frame(1'b0, 29'h2AA, 1'b0, 4'd8, {$urandom, $urandom}, -1, 1'b1);
        clear_counts();
        for (int i = 0; i < 30; i++) send_bit(tx[i]);
        check_eq("mid.busy_pre", 32'(snap_busy), 32'd1);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("mid.crc_clear", 32'(CRC_CLEAR), 32'd1);
        check_eq("mid.busy", 32'(BUSY), 32'd0);
        check_eq("mid.crc_strb", 32'(CRC_STRB), 32'd0);
        check_eq("mid.id", 32'(ID), 32'd0);
        check_eq("mid.ide_rtr_dlc", 32'({IDE, RTR, DLC}), 32'd0);
        m_id = '0; m_ide = 1'b0; m_rtr = 1'b0; m_dlc = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        run_frame("noint", 1'b0, 29'h321, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000, -1, 1'b1, 1'b0);
        idle_bits(11);
        run_frame("postrst", 1'b0, 29'h321, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000, -1, 1'b1, 1'b1);

        check_eq("strb_vs_clear", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
